// File: rtl/bcd_conv_sched_if.sv
// Request/result bundle between requesters, the scheduler and the shared BIN2BCD converter.
// Latency: none (wires only).
// Backpressure: REQ is held by each requester until its DONE; the scheduler never stalls mid-conversion.
interface bcd_conv_sched_if #(
    parameter int N_REQ = 4,
    parameter int BIN_W = 10
);
    logic [N_REQ-1:0]       REQ;
    logic [N_REQ*BIN_W-1:0] BIN_IN;
    logic [N_REQ-1:0]       GNT;
    logic                   DONE;
    logic                   BUSY;
    logic [15:0]            BCD_OUT;
    logic                   CONV_CLR;
    logic                   CONV_EN;
    logic [BIN_W-1:0]       CONV_BIN;
    logic [15:0]            CONV_BCD;

    // Scheduler side
    modport slave (
        input  REQ, BIN_IN, CONV_BCD,
        output GNT, DONE, BUSY, BCD_OUT, CONV_CLR, CONV_EN, CONV_BIN
    );

    // Requesters plus converter side
    modport master (
        output REQ, BIN_IN, CONV_BCD,
        input  GNT, DONE, BUSY, BCD_OUT, CONV_CLR, CONV_EN, CONV_BIN
    );
endinterface

// File: rtl/bcd_conv_sched.sv
// Round-robin sharing of one serial BIN2BCD converter: clear, CONV_CYCLES enabled clocks, capture.
// Latency: DONE 14 cycles after the granting edge; 16-cycle service period at default parameters.
// Backpressure: requesters hold REQ until DONE; others wait in IDLE arbitration. Optional: LEADING_ZERO_BLANK_EN.
module bcd_conv_sched #(
    parameter int N_REQ       = 4,
    parameter int BIN_W       = 10,
    parameter int CONV_CYCLES = 12
) (
    input  logic               CLK,
    input  logic               RESET,
    bcd_conv_sched_if.slave    bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [N_REQ-1:0] GNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

    logic [2:0]       state;
    logic             clr_q;
    logic [PTR_W-1:0] rr_ptr;
    logic [CNT_W-1:0] count;
    logic [N_REQ-1:0] gnt_q;
    logic             done_q;
    logic [15:0]      bcd_q;
    logic [BIN_W-1:0] bin_q;

    logic             win_vld;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] ptr_nxt;
    logic [BIN_W-1:0] win_bin;
    logic [15:0]      bcd_cap;
    int               arb_idx;

    // Round-robin pick: scan downward so the lowest offset from the pointer is the last write
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        arb_idx = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            arb_idx = (int'(rr_ptr) + k) % N_REQ;
            if (bus.REQ[arb_idx]) begin
                win_vld = 1'b1;
                win     = PTR_W'(arb_idx);
            end
        end
        ptr_nxt = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
        win_bin = bus.BIN_IN[int'(win)*BIN_W +: BIN_W];
    end

    // Result shaping at capture: optional blanking of leading zero digits (units never blanked)
    always_comb begin
        bcd_cap = bus.CONV_BCD;
`ifdef LEADING_ZERO_BLANK_EN
        if (bus.CONV_BCD[15:12] == 4'd0) begin
            bcd_cap[15:12] = 4'hF;
            if (bus.CONV_BCD[11:8] == 4'd0) begin
                bcd_cap[11:8] = 4'hF;
                if (bus.CONV_BCD[7:4] == 4'd0) begin
                    bcd_cap[7:4] = 4'hF;
                end
            end
        end
`endif
    end

    // Service sequencer: grant, converter clear, enable window, capture, release
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= ST_IDLE;
            clr_q  <= 1'b0;
            rr_ptr <= '0;
            count  <= '0;
            gnt_q  <= '0;
            done_q <= 1'b0;
            bcd_q  <= '0;
            bin_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        gnt_q  <= GNT_ONE << win;
                        bin_q  <= win_bin;
                        rr_ptr <= ptr_nxt;
                        clr_q  <= 1'b1;
                        state  <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    clr_q <= 1'b0;
                    count <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    count <= count + 1'b1;
                    if (count == CNT_LAST) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    bcd_q  <= bcd_cap;
                    done_q <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    gnt_q  <= '0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Converter controls decoded from state; reset also clears the converter
    assign bus.CONV_CLR = RESET | clr_q;
    assign bus.CONV_EN  = (state == ST_RUN);
    assign bus.CONV_BIN = bin_q;
    assign bus.BUSY     = (state != ST_IDLE);
    assign bus.GNT      = gnt_q;
    assign bus.DONE     = done_q;
    assign bus.BCD_OUT  = bcd_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed and randomized services against a behavioural converter and a reference arbiter/BCD model.
// Latency checked: grant visible after edge0, DONE at edge14, 12 enabled cycles, release at edge15.
// Requesters hold REQ until DONE; reset mid-run and REQ drop mid-run are exercised.
module tb_bcd_conv_sched;
    logic CLK;
    logic RESET;
    int   tests = 0;
    int   fails = 0;
    int   m_ptr = 0;

    bcd_conv_sched_if #(.N_REQ(4), .BIN_W(10)) bus ();

    bcd_conv_sched #(.N_REQ(4), .BIN_W(10), .CONV_CYCLES(12)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Decimal digits of an operand, computed arithmetically
    function automatic logic [15:0] raw_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] exp_bcd(input int v);
        logic [15:0] r;
        r = raw_bcd(v);
`ifdef LEADING_ZERO_BLANK_EN
        if (v < 1000) r[15:12] = 4'hF;
        if (v < 100)  r[11:8]  = 4'hF;
        if (v < 10)   r[7:4]   = 4'hF;
`endif
        return r;
    endfunction

    // Behavioural converter: latches BIN on its first enabled edge, result after 12 enabled edges
    logic [15:0] cv_out;
    logic [9:0]  cv_bin;
    int          cv_cnt;
    always @(posedge CLK or posedge bus.CONV_CLR) begin
        if (bus.CONV_CLR) begin
            cv_cnt <= 0;
            cv_out <= 16'h0;
            cv_bin <= 10'h0;
        end else if (bus.CONV_EN) begin
            if (cv_cnt == 0) cv_bin <= bus.CONV_BIN;
            if (cv_cnt == 11) cv_out <= raw_bcd(int'(cv_bin));
            cv_cnt <= cv_cnt + 1;
        end
    end
    assign bus.CONV_BCD = cv_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin: first requester at or after the pointer
    function automatic int pick(input logic [3:0] mask);
        for (int k = 0; k < 4; k++) begin
            if (mask[(m_ptr + k) % 4]) begin
                int w;
                w = (m_ptr + k) % 4;
                m_ptr = (w + 1) % 4;
                return w;
            end
        end
        return -1;
    endfunction

    function automatic int slice(input int idx);
        return int'(bus.BIN_IN[idx*10 +: 10]);
    endfunction

    // One full service; mut_n>0 drops the requester's REQ and scrambles its operand at that cycle
    task automatic run_one(input string tag, input int exp_idx, input logic [15:0] exp_res,
                           input int mut_n, input bit chk_w);
        int w;
        int done_n;
        int en;
        w = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            w++;
            if (bus.GNT != 4'b0) break;
        end
        chk({tag, "_gnt"}, 32'(bus.GNT), 32'(1 << exp_idx));
        if (chk_w) chk({tag, "_period"}, 32'(w), 32'd1);
        chk({tag, "_clr"}, 32'(bus.CONV_CLR), 32'd1);
        chk({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
        done_n = -1;
        en = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK);
            if (n == mut_n) begin
                bus.REQ[exp_idx] = 1'b0;
                bus.BIN_IN[exp_idx*10 +: 10] = 10'($urandom);
            end
            if (bus.CONV_EN) en++;
            if (bus.DONE) begin
                done_n = n;
                break;
            end
        end
        chk({tag, "_done_lat"}, 32'(done_n), 32'd14);
        chk({tag, "_en_cycles"}, 32'(en), 32'd12);
        chk({tag, "_bcd"}, 32'(bus.BCD_OUT), 32'(exp_res));
        @(negedge CLK);
        chk({tag, "_done_pulse"}, 32'(bus.DONE), 32'd0);
        chk({tag, "_gnt_rel"}, 32'(bus.GNT), 32'd0);
        chk({tag, "_bcd_hold"}, 32'(bus.BCD_OUT), 32'(exp_res));
    endtask

    task automatic serve(input string tag, input logic [3:0] mask, input int mut_n, input bit chk_w);
        int wi;
        bus.REQ = mask;
        wi = pick(mask);
        run_one(tag, wi, exp_bcd(slice(wi)), mut_n, chk_w);
    endtask

    initial begin
        int   saw;
        int   wi;
        logic [15:0] e;
        RESET      = 1'b1;
        bus.REQ    = 4'b0;
        bus.BIN_IN = '0;
        repeat (2) @(negedge CLK);
        chk("rst_gnt", 32'(bus.GNT), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_bcd", 32'(bus.BCD_OUT), 32'd0);
        chk("rst_en", 32'(bus.CONV_EN), 32'd0);
        chk("rst_bin", 32'(bus.CONV_BIN), 32'd0);
        chk("rst_clr", 32'(bus.CONV_CLR), 32'd1);
        RESET = 1'b0;
        @(negedge CLK);
        chk("idle_clr", 32'(bus.CONV_CLR), 32'd0);
        chk("idle_busy", 32'(bus.BUSY), 32'd0);

        // Single requester 0, operand 999
        bus.BIN_IN[0*10 +: 10] = 10'd999;
        serve("r0_999", 4'b0001, 0, 1'b0);
        // Requester 2 alone with max operand
        bus.BIN_IN[2*10 +: 10] = 10'd1023;
        serve("r2_1023", 4'b0100, 0, 1'b1);
        bus.BIN_IN[3*10 +: 10] = 10'd45;
        serve("r3_45", 4'b1000, 0, 1'b1);

        // All four held: rotation 0,1,2,3,0 with back-to-back service
        bus.BIN_IN = {10'd1023, 10'd3, 10'd2, 10'd1};
        serve("all_a", 4'b1111, 0, 1'b1);
        serve("all_b", 4'b1111, 0, 1'b1);
        serve("all_c", 4'b1111, 0, 1'b1);
        serve("all_d", 4'b1111, 0, 1'b1);
        serve("all_e", 4'b1111, 0, 1'b1);
        bus.BIN_IN[0*10 +: 10] = 10'd0;
        serve("r0_zero", 4'b0001, 0, 1'b1);

        // Requester 1 drops REQ and changes its operand mid-run; requester 2 next
        bus.BIN_IN[1*10 +: 10] = 10'd321;
        bus.BIN_IN[2*10 +: 10] = 10'd58;
        bus.REQ = 4'b0110;
        wi = pick(4'b0110);
        run_one("drop_r1", wi, exp_bcd(321), 6, 1'b1);
        serve("after_drop", 4'b0100, 0, 1'b1);

        // Reset during RUN: immediate idle, converter cleared, no DONE, pointer back to 0
        bus.BIN_IN[1*10 +: 10] = 10'd500;
        bus.REQ = 4'b0010;
        wi = pick(4'b0010);
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.GNT != 4'b0) break;
        end
        chk("mid_gnt", 32'(bus.GNT), 32'(1 << wi));
        repeat (7) @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(bus.GNT), 32'd0);
        chk("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        chk("mid_rst_clr", 32'(bus.CONV_CLR), 32'd1);
        chk("mid_rst_en", 32'(bus.CONV_EN), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        bus.REQ = 4'b0;
        m_ptr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.DONE || bus.BUSY) saw = 1;
        end
        chk("post_rst_quiet", 32'(saw), 32'd0);
        bus.BIN_IN[0*10 +: 10] = 10'd7;
        serve("post_rst_7", 4'b1111, 0, 1'b0);

        // Randomized request masks and operands, each new mask applied at the release cycle
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < 4; j++) bus.BIN_IN[j*10 +: 10] = 10'($urandom_range(0, 1023));
            e = 16'(r);
            serve($sformatf("rnd%0d", r), 4'($urandom_range(1, 15)), 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
- Round-robin scheduler that shares one serial BIN2BCD converter among N_REQ requesters, e.g. frequency-meter channels and period/display paths.
- Sequences the converter: clear, enable window, result capture.
- Returns the 16-bit BCD result and a DONE pulse to the granted requester.
- Sits between the channel counters and the display/formatting logic.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BIN_W, 10, binary operand width; must match converter input.
- CONV_CYCLES, 12, enabled clocks per conversion: 1 latch + 10 shifts + 1 output latch.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset.
- REQ  in  N_REQ  per-requester request; held until DONE.
- BIN_IN  in  N_REQ*BIN_W  packed operands; requester i in [i*BIN_W +: BIN_W].
- GNT  out  N_REQ  one-hot grant.
- DONE  out  1  one-cycle result-valid pulse for current GNT holder.
- BUSY  out  1  high in any state except IDLE.
- BCD_OUT  out  16  captured result {T,H,D,U}.
- CONV_CLR  out  1  drives converter RESET.
- CONV_EN  out  1  drives converter ENABLE.
- CONV_BIN  out  BIN_W  drives converter BIN.
- CONV_BCD  in  16  converter {BCD_T,BCD_H,BCD_D,BCD_U}.

Behaviour:
- Reset: RESET is asynchronous, active-high; clock is CLK; all flops on posedge CLK.
- Reset values: GNT=0, DONE=0, BUSY=0, BCD_OUT=0, CONV_EN=0, CONV_BIN=0, state=IDLE, RR pointer=0, cycle count=0.
- CONV_CLR = RESET OR registered clr_q; converter is reset together with the scheduler.
- FSM states: IDLE, CLEAR, RUN, CAPTURE, DONE_ST. Edge numbers below are relative to edge0, the edge that first samples REQ.
- IDLE: if REQ!=0 at edge0 then
  - GNT <= winner;
  - CONV_BIN <= winner's BIN_IN slice, held stable until the next grant;
  - clr_q <= 1; go to CLEAR.
- CLEAR (one cycle, CONV_CLR=1): at edge1 clr_q <= 0, count <= 0, go to RUN.
- RUN: CONV_EN=1, decoded combinationally from the state.
  - Converter sees exactly CONV_CYCLES enabled edges (edges 2..13 at default).
  - count increments each edge; at count==CONV_CYCLES-1 (edge13) go to CAPTURE.
- CAPTURE: CONV_EN=0. At edge14: BCD_OUT <= CONV_BCD, DONE <= 1, go to DONE_ST.
- DONE_ST: at edge15: DONE <= 0, GNT <= 0, go to IDLE.
- Latency: DONE high 14 cycles after edge0; next grant earliest at edge16 (16-cycle service period at default).
- BCD_OUT holds its value until the next CAPTURE.
- Arbitration: round robin. Search starts at (last_granted+1) mod N_REQ; pointer updates on grant. Single requester is served repeatedly with no starvation.
- Simultaneous requests: lowest index at or after the pointer wins.
- REQ dropped mid-service: no abort. Conversion completes, DONE still pulses, GNT released normally.
- REQ changes of non-granted requesters during service are ignored until IDLE.
- BIN_IN changes after grant do not affect the current conversion.
- RESET mid-conversion: FSM returns to IDLE immediately; converter is cleared via CONV_CLR; no DONE; pointer=0.
- Operand range: full 0..2^BIN_W-1. BIN_W=10 gives max 1023, which fits 4 BCD digits; no overflow handling needed.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: at CAPTURE each leading zero digit of CONV_BCD (from T down to D) is replaced by 4'hF, the blank code for the 7-segment decoder. The units digit is never blanked.
- Not defined: BCD_OUT = CONV_BCD unmodified.

Test Plan:
- REQ=4'b0001, BIN_IN[9:0]=999 → GNT=0001 after edge0; CONV_EN high exactly 12 cycles; DONE pulse at edge14; BCD_OUT=16'h0999 (16'hF999 with blanking).
- REQ=4'b1111 held, BIN_IN = 1, 2, 3, 1023 → grants in order 0,1,2,3,0; results 0001, 0002, 0003, 1023 (hex BCD); period 16 cycles.
- BIN_IN=1023 on requester 2 alone → BCD_OUT=16'h1023, GNT=0100.
- RESET asserted at RUN count 5 → GNT=0, BUSY=0, CONV_CLR=1 immediately, no DONE; after release, a new REQ with BIN=7 gives BCD_OUT=16'h0007.
- Requester 1 drops REQ in RUN → DONE still pulses at edge14, GNT clears at edge15, requester 2 granted next.
- With LEADING_ZERO_BLANK_EN: BIN=0 → BCD_OUT=16'hFFF0; BIN=45 → 16'hFF45.
